mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 2-slot (upper/lower) pipeline. It consumes the execute stage's registered outputs and performs loads and stores for the upper slot against a synchronous data BRAM.
- It stalls execute while a load is in flight.
- It forwards both slots, with their write-back data and destination registers, to write-back.

Parameters:
- ADDR_W, 16: word-address width of the data BRAM.
- LOAD_LAT, 1: BRAM read latency in cycles, legal range 1..3. rdata is valid LOAD_LAT cycles after the en cycle.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- ex_to_mem_ready  in  1  execute flags a load in the upper slot.
- inst  in  64  bundle from execute; bubble is {3'b111,29'b0} per slot.
- u_tdata  in  32  upper result; the byte address for load/store.
- u_store_data  in  32  store data for the upper slot.
- u_rt  in  5  upper destination register.
- u_rt_flag  in  1  upper write enable.
- l_tdata  in  32  lower result.
- l_rt  in  5  lower destination register.
- l_rt_flag  in  1  lower write enable.
- mem_stall  out  1  combinational; drives execute's exec_stall.
- dmem_en  out  1  BRAM enable.
- dmem_we  out  1  BRAM write enable.
- dmem_addr  out  ADDR_W  word address = u_tdata[ADDR_W+1:2].
- dmem_wdata  out  32  store data.
- dmem_rdata  in  32  BRAM read data.
- inst_to_wb  out  64  bundle to write-back.
- u_wdata  out  32  upper write-back value.
- u_rt_to_wb  out  5  upper destination register.
- u_rt_flag_to_wb  out  1  upper write enable.
- l_wdata  out  32  lower write-back value.
- l_rt_to_wb  out  5  lower destination register.
- l_rt_flag_to_wb  out  1  lower write enable.

Behaviour:
- Opcode is inst[63:58].
  - OP_LOAD = 6'b010000.
  - OP_STORE = 6'b010001.
  - Only the upper slot issues memory operations.
  - Load is recognised only when ex_to_mem_ready=1 and opcode==OP_LOAD.
- Reset (synchronous, rstn=0):
  - state=IDLE, cnt=0.
  - u_rt_flag_to_wb=0, l_rt_flag_to_wb=0, inst_to_wb=bubble.
  - u_wdata=0, l_wdata=0, rt_to_wb=0.
  - dmem_en=0, dmem_we=0, mem_stall=0.
  - A reset during WAIT abandons the load; late dmem_rdata is ignored.
- FSM states: IDLE, WAIT.
- IDLE, non-memory input:
  - Register all fields to the outputs next edge, latency 1.
  - u_wdata=u_tdata, l_wdata=l_tdata.
  - mem_stall=0.
- IDLE, store:
  - Same cycle: dmem_en=1, dmem_we=1, addr from u_tdata, dmem_wdata=u_store_data.
  - Pass through as non-memory, but u_rt_flag_to_wb=0 regardless of input.
  - No stall.
- IDLE, load:
  - Same cycle: dmem_en=1, dmem_we=0, mem_stall=1.
  - Latch inst, u_rt, u_rt_flag and the lower-slot fields into hold registers. Execute emits a bubble on stall, so the inputs are not held.
  - cnt<=LOAD_LAT-1; state<=WAIT.
  - Outputs next edge: bubble, both rt_flags 0.
- WAIT, cnt!=0:
  - mem_stall=1, cnt--, outputs bubble.
  - Inputs ignored.
- WAIT, cnt==0:
  - dmem_rdata is valid this cycle; mem_stall=0.
  - Next edge: outputs take the hold registers, with u_wdata=dmem_rdata.
  - state<=IDLE.
  - Inputs present this cycle are ignored. Execute is still outputting the stall bubble; it resumes after this edge.
- Load total occupancy: LOAD_LAT+1 cycles. mem_stall is high for LOAD_LAT cycles.
- Lower slot retires in the same output cycle as its paired upper load.
- dmem_en and dmem_we are 0 in every cycle not listed above.
- Address bits [1:0] and bits above ADDR_W+1 are ignored.

Decomposition:
- Shared package pipe_pkg holds:
  - OP_LOAD, OP_STORE.
  - BUBBLE_SLOT (32'hE000_0000).
  - exec_type enum (ENop/EAdd/ESub/ERshift/ELshift), moved from execute.
  - mem_state_t {IDLE, WAIT}.
- No sub-module; the hold register and FSM are small enough to stay inline.

Test Plan:
- Plain op: inst upper EAdd result u_tdata=5, u_rt=3, flag=1 -> next cycle u_wdata=5, u_rt_to_wb=3, flag=1; mem_stall never high.
- Store: OP_STORE, u_tdata=0x40, u_store_data=0xDEADBEEF -> same cycle dmem_en=1, we=1, addr=0x10, wdata=0xDEADBEEF; next cycle u_rt_flag_to_wb=0.
- Load, LOAD_LAT=1, BRAM[0x10]=0x12345678, u_rt=7, with lower l_tdata=9, l_rt=2:
  - mem_stall high exactly 1 cycle; bubble output 1 cycle.
  - Then u_wdata=0x12345678, u_rt_to_wb=7, l_wdata=9, l_rt_to_wb=2, together.
- Load, LOAD_LAT=3:
  - mem_stall high 3 cycles; execute's bubble inputs during WAIT are never forwarded.
  - Result appears at cycle 4.
- Back-to-back: load then store to the same address -> store issues only after the load retires; the load returns the old value.
- Reset asserted during WAIT -> next cycle all flags 0, mem_stall=0, state IDLE; a following plain op passes normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, bubble encoding, execute op types
// and the memory-stage FSM state type.
package pipe_pkg;

    localparam logic [5:0]  OP_LOAD     = 6'b010000;
    localparam logic [5:0]  OP_STORE    = 6'b010001;

    // One slot's worth of "no instruction"; a full bundle is two of these.
    localparam logic [31:0] BUBBLE_SLOT = 32'hE000_0000;
    localparam logic [63:0] BUBBLE_INST = {BUBBLE_SLOT, BUBBLE_SLOT};

    typedef enum logic [2:0] {
        ENop,
        EAdd,
        ESub,
        ERshift,
        ELshift
    } exec_type;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_t;

    // The opcode of the upper slot sits at the top of the bundle.
    function automatic logic [5:0] opcode_of(input logic [63:0] bundle);
        return bundle[63:58];
    endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory stage: issues upper-slot loads/stores to a synchronous data BRAM,
// stalls execute while a load is outstanding and forwards both slots to
// write-back. LOAD_LAT must be 1..3 (the wait counter is two bits wide).
module mem_stage
    import pipe_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ex_to_mem_ready,
    input  logic [63:0]       inst,
    input  logic [31:0]       u_tdata,
    input  logic [31:0]       u_store_data,
    input  logic [4:0]        u_rt,
    input  logic              u_rt_flag,
    input  logic [31:0]       l_tdata,
    input  logic [4:0]        l_rt,
    input  logic              l_rt_flag,
    output logic              mem_stall,
    output logic              dmem_en,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    output logic [63:0]       inst_to_wb,
    output logic [31:0]       u_wdata,
    output logic [4:0]        u_rt_to_wb,
    output logic              u_rt_flag_to_wb,
    output logic [31:0]       l_wdata,
    output logic [4:0]        l_rt_to_wb,
    output logic              l_rt_flag_to_wb
);

    localparam logic [1:0] CNT_START = 2'(LOAD_LAT - 1);

    mem_state_t  r_state;
    mem_state_t  w_state_next;
    logic [1:0]  r_cnt;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_load_go;
    logic        w_store_go;
    logic        w_load_done;
    logic        w_unused_addr_bits;

    // Load context captured at issue; execute does not hold its outputs.
    logic [63:0] r_hold_inst;
    logic [4:0]  r_hold_u_rt;
    logic        r_hold_u_rt_flag;
    logic [31:0] r_hold_l_tdata;
    logic [4:0]  r_hold_l_rt;
    logic        r_hold_l_rt_flag;

    logic [63:0] r_inst_to_wb;
    logic [31:0] r_u_wdata;
    logic [4:0]  r_u_rt_to_wb;
    logic        r_u_rt_flag_to_wb;
    logic [31:0] r_l_wdata;
    logic [4:0]  r_l_rt_to_wb;
    logic        r_l_rt_flag_to_wb;

    assign w_is_load   = ex_to_mem_ready && (opcode_of(inst) == OP_LOAD);
    assign w_is_store  = (opcode_of(inst) == OP_STORE);
    assign w_load_go   = (r_state == IDLE) && w_is_load;
    assign w_store_go  = (r_state == IDLE) && w_is_store;
    assign w_load_done = (r_state == WAIT) && (r_cnt == 2'd0);

    // Byte offset and high address bits play no part in the word address.
    assign w_unused_addr_bits = ^{u_tdata[31:ADDR_W+2], u_tdata[1:0]};

    assign dmem_addr  = u_tdata[ADDR_W+1:2];
    assign dmem_wdata = u_store_data;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // FSM next state: a load parks us in WAIT until its data is back.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_is_load)        w_state_next = WAIT;
            WAIT:    if (r_cnt == 2'd0)    w_state_next = IDLE;
            default:                       w_state_next = IDLE;
        endcase
    end

    // FSM outputs: BRAM strobes and the stall back to execute; all quiet in reset.
    always_comb begin
        mem_stall = 1'b0;
        dmem_en   = 1'b0;
        dmem_we   = 1'b0;
        if (rstn) begin
            mem_stall = w_load_go || ((r_state == WAIT) && (r_cnt != 2'd0));
            dmem_en   = w_load_go || w_store_go;
            dmem_we   = w_store_go;
        end
    end

    // Wait counter: the cycle it reaches zero is the cycle rdata is valid.
    always_ff @(posedge clk) begin
        if (!rstn)                               r_cnt <= 2'd0;
        else if (w_load_go)                      r_cnt <= CNT_START;
        else if ((r_state == WAIT) && (r_cnt != 2'd0)) r_cnt <= r_cnt - 2'd1;
    end

    // Capture the load's bundle and the paired lower slot at issue.
    always_ff @(posedge clk) begin
        if (w_load_go) begin
            r_hold_inst      <= inst;
            r_hold_u_rt      <= u_rt;
            r_hold_u_rt_flag <= u_rt_flag;
            r_hold_l_tdata   <= l_tdata;
            r_hold_l_rt      <= l_rt;
            r_hold_l_rt_flag <= l_rt_flag;
        end
    end

    // Write-back register: load result, bubble while busy, else pass-through.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_inst_to_wb      <= BUBBLE_INST;
            r_u_wdata         <= 32'd0;
            r_u_rt_to_wb      <= 5'd0;
            r_u_rt_flag_to_wb <= 1'b0;
            r_l_wdata         <= 32'd0;
            r_l_rt_to_wb      <= 5'd0;
            r_l_rt_flag_to_wb <= 1'b0;
        end else if (w_load_done) begin
            r_inst_to_wb      <= r_hold_inst;
            r_u_wdata         <= dmem_rdata;
            r_u_rt_to_wb      <= r_hold_u_rt;
            r_u_rt_flag_to_wb <= r_hold_u_rt_flag;
            r_l_wdata         <= r_hold_l_tdata;
            r_l_rt_to_wb      <= r_hold_l_rt;
            r_l_rt_flag_to_wb <= r_hold_l_rt_flag;
        end else if (w_load_go || (r_state == WAIT)) begin
            r_inst_to_wb      <= BUBBLE_INST;
            r_u_wdata         <= 32'd0;
            r_u_rt_to_wb      <= 5'd0;
            r_u_rt_flag_to_wb <= 1'b0;
            r_l_wdata         <= 32'd0;
            r_l_rt_to_wb      <= 5'd0;
            r_l_rt_flag_to_wb <= 1'b0;
        end else begin
            r_inst_to_wb      <= inst;
            r_u_wdata         <= u_tdata;
            r_u_rt_to_wb      <= u_rt;
            // A store has no register result even if execute flagged one.
            r_u_rt_flag_to_wb <= u_rt_flag && !w_is_store;
            r_l_wdata         <= l_tdata;
            r_l_rt_to_wb      <= l_rt;
            r_l_rt_flag_to_wb <= l_rt_flag;
        end
    end

    assign inst_to_wb      = r_inst_to_wb;
    assign u_wdata         = r_u_wdata;
    assign u_rt_to_wb      = r_u_rt_to_wb;
    assign u_rt_flag_to_wb = r_u_rt_flag_to_wb;
    assign l_wdata         = r_l_wdata;
    assign l_rt_to_wb      = r_l_rt_to_wb;
    assign l_rt_flag_to_wb = r_l_rt_flag_to_wb;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: two instances (LOAD_LAT 1 and 3), each with a
// behavioural BRAM, exercised one at a time through a scoreboard queue.
module tb_mem_stage;
    import pipe_pkg::*;

    typedef struct packed {
        logic        rdy;
        logic [63:0] inst;
        logic [31:0] u_tdata;
        logic [31:0] u_store;
        logic [4:0]  u_rt;
        logic        u_flag;
        logic [31:0] l_tdata;
        logic [4:0]  l_rt;
        logic        l_flag;
    } in_t;

    typedef struct packed {
        logic        full;   // compare data/rt fields too, not just inst/flags
        logic [63:0] inst;
        logic [31:0] u_wdata;
        logic [4:0]  u_rt;
        logic        u_flag;
        logic [31:0] l_wdata;
        logic [4:0]  l_rt;
        logic        l_flag;
    } wb_t;

    localparam logic [5:0] OPC_ADD = 6'b000001;
    localparam logic [5:0] OPC_SUB = 6'b000010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        t_rdy     [2];
    logic [63:0] t_inst    [2];
    logic [31:0] t_u_tdata [2];
    logic [31:0] t_u_store [2];
    logic [4:0]  t_u_rt    [2];
    logic        t_u_flag  [2];
    logic [31:0] t_l_tdata [2];
    logic [4:0]  t_l_rt    [2];
    logic        t_l_flag  [2];

    logic        o_stall   [2];
    logic        d_en      [2];
    logic        d_we      [2];
    logic [15:0] d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic [31:0] d_rdata   [2];
    logic [63:0] o_inst    [2];
    logic [31:0] o_u_wdata [2];
    logic [4:0]  o_u_rt    [2];
    logic        o_u_flag  [2];
    logic [31:0] o_l_wdata [2];
    logic [4:0]  o_l_rt    [2];
    logic        o_l_flag  [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            localparam int LAT = (gi == 0) ? 1 : 3;
            logic [31:0] bram    [0:255];
            logic [31:0] rd_pipe [0:2];

            initial begin
                for (int a = 0; a < 256; a++) bram[a] = 32'h1000_0000 + a;
                bram[16] = (gi == 0) ? 32'h1234_5678 : 32'hCAFE_F00D;
            end

            // Read data is valid exactly LAT cycles after the enable cycle;
            // any other cycle shows a poison value.
            always @(posedge clk) begin
                if (d_en[gi] && d_we[gi]) bram[d_addr[gi][7:0]] <= d_wdata[gi];
                rd_pipe[0] <= (d_en[gi] && !d_we[gi]) ? bram[d_addr[gi][7:0]] : 32'hBAD0_BAD0;
                rd_pipe[1] <= rd_pipe[0];
                rd_pipe[2] <= rd_pipe[1];
            end
            assign d_rdata[gi] = rd_pipe[LAT-1];

            mem_stage #(.ADDR_W(16), .LOAD_LAT(LAT)) u_dut (
                .clk             (clk),
                .rstn            (rstn),
                .ex_to_mem_ready (t_rdy[gi]),
                .inst            (t_inst[gi]),
                .u_tdata         (t_u_tdata[gi]),
                .u_store_data    (t_u_store[gi]),
                .u_rt            (t_u_rt[gi]),
                .u_rt_flag       (t_u_flag[gi]),
                .l_tdata         (t_l_tdata[gi]),
                .l_rt            (t_l_rt[gi]),
                .l_rt_flag       (t_l_flag[gi]),
                .mem_stall       (o_stall[gi]),
                .dmem_en         (d_en[gi]),
                .dmem_we         (d_we[gi]),
                .dmem_addr       (d_addr[gi]),
                .dmem_wdata      (d_wdata[gi]),
                .dmem_rdata      (d_rdata[gi]),
                .inst_to_wb      (o_inst[gi]),
                .u_wdata         (o_u_wdata[gi]),
                .u_rt_to_wb      (o_u_rt[gi]),
                .u_rt_flag_to_wb (o_u_flag[gi]),
                .l_wdata         (o_l_wdata[gi]),
                .l_rt_to_wb      (o_l_rt[gi]),
                .l_rt_flag_to_wb (o_l_flag[gi])
            );
        end
    endgenerate

    int  n_checks = 0;
    int  n_pass   = 0;
    wb_t sb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic in_t mk(input logic [5:0] op, input logic rdy,
                               input logic [31:0] ut, input logic [31:0] us,
                               input logic [4:0] urt, input logic uf,
                               input logic [31:0] lt, input logic [4:0] lrt, input logic lf);
        in_t r;
        r.rdy     = rdy;
        r.inst    = {op, 26'h0_0ABC, 32'h0400_0001};
        r.u_tdata = ut;
        r.u_store = us;
        r.u_rt    = urt;
        r.u_flag  = uf;
        r.l_tdata = lt;
        r.l_rt    = lrt;
        r.l_flag  = lf;
        return r;
    endfunction

    function automatic in_t idle_in();
        in_t r;
        r      = '0;
        r.inst = BUBBLE_INST;
        return r;
    endfunction

    // Expected write-back record for an instruction that passes straight through.
    function automatic wb_t pass(input in_t i);
        wb_t r;
        r.full    = 1'b1;
        r.inst    = i.inst;
        r.u_wdata = i.u_tdata;
        r.u_rt    = i.u_rt;
        r.u_flag  = i.u_flag && (i.inst[63:58] != OP_STORE);
        r.l_wdata = i.l_tdata;
        r.l_rt    = i.l_rt;
        r.l_flag  = i.l_flag;
        return r;
    endfunction

    function automatic wb_t bub();
        wb_t r;
        r      = '0;
        r.inst = BUBBLE_INST;
        return r;
    endfunction

    function automatic wb_t rst_rec();
        wb_t r;
        r      = bub();
        r.full = 1'b1;
        return r;
    endfunction

    task automatic drive(input int k, input in_t i);
        t_rdy[k]     = i.rdy;
        t_inst[k]    = i.inst;
        t_u_tdata[k] = i.u_tdata;
        t_u_store[k] = i.u_store;
        t_u_rt[k]    = i.u_rt;
        t_u_flag[k]  = i.u_flag;
        t_l_tdata[k] = i.l_tdata;
        t_l_rt[k]    = i.l_rt;
        t_l_flag[k]  = i.l_flag;
    endtask

    // Compare the registered outputs against the oldest expected record.
    task automatic cmp_wb(input int k);
        wb_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("dut%0d inst_to_wb", k), o_inst[k], e.inst);
            check($sformatf("dut%0d u_rt_flag_to_wb", k), o_u_flag[k], e.u_flag);
            check($sformatf("dut%0d l_rt_flag_to_wb", k), o_l_flag[k], e.l_flag);
            if (e.full) begin
                check($sformatf("dut%0d u_wdata", k), o_u_wdata[k], e.u_wdata);
                check($sformatf("dut%0d u_rt_to_wb", k), o_u_rt[k], e.u_rt);
                check($sformatf("dut%0d l_wdata", k), o_l_wdata[k], e.l_wdata);
                check($sformatf("dut%0d l_rt_to_wb", k), o_l_rt[k], e.l_rt);
            end
        end
    endtask

    // One clock cycle: check last edge's outputs, drive, check same-cycle strobes.
    task automatic step(input int k, input in_t i, input logic rn,
                        input logic e_stall, input logic e_en, input logic e_we,
                        input logic [15:0] e_addr, input wb_t nxt);
        @(negedge clk);
        cmp_wb(k);
        rstn = rn;
        drive(k, i);
        #1;
        check($sformatf("dut%0d mem_stall", k), o_stall[k], e_stall);
        check($sformatf("dut%0d dmem_en", k), d_en[k], e_en);
        check($sformatf("dut%0d dmem_we", k), d_we[k], e_we);
        if (e_en) check($sformatf("dut%0d dmem_addr", k), d_addr[k], e_addr);
        if (e_we) check($sformatf("dut%0d dmem_wdata", k), d_wdata[k], i.u_store);
        sb.push_back(nxt);
        $display("t=%0t dut%0d rstn=%0b op=%02h ut=%08h stall=%0b en=%0b we=%0b",
                 $time, k, rn, i.inst[63:58], i.u_tdata, o_stall[k], d_en[k], d_we[k]);
    endtask

    task automatic plain(input int k, input in_t i);
        logic st;
        st = (i.inst[63:58] == OP_STORE);
        step(k, i, 1'b1, 1'b0, st, st, i.u_tdata[17:2], pass(i));
    endtask

    // A full load: issue, LAT-1 stalled waits, then the data cycle. Execute
    // keeps presenting a store during the wait; it must be ignored.
    task automatic load(input int k, input int lat, input logic [31:0] ut,
                        input logic [4:0] urt, input logic uf, input logic [31:0] lt,
                        input logic [4:0] lrt, input logic lf, input logic [31:0] exp_rd);
        in_t li;
        in_t junk;
        wb_t res;
        li   = mk(OP_LOAD, 1'b1, ut, 32'h0, urt, uf, lt, lrt, lf);
        junk = mk(OP_STORE, 1'b1, 32'h0000_0080, 32'h5555_AAAA, 5'd31, 1'b1, 32'h77, 5'd30, 1'b1);
        step(k, li, 1'b1, 1'b1, 1'b1, 1'b0, ut[17:2], bub());
        for (int c = 1; c < lat; c++)
            step(k, junk, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, bub());
        res         = pass(li);
        res.u_wdata = exp_rd;
        step(k, junk, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, res);
    endtask

    task automatic drain(input int k);
        @(negedge clk);
        cmp_wb(k);
    endtask

    initial begin
        rstn = 1'b0;
        drive(0, idle_in());
        drive(1, idle_in());

        // Reset: all strobes low during reset, bubble/zero outputs afterwards.
        step(0, idle_in(), 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, rst_rec());
        step(0, idle_in(), 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, rst_rec());

        // LOAD_LAT = 1 instance.
        plain(0, mk(OPC_ADD, 1'b0, 32'd5, 32'h0, 5'd3, 1'b1, 32'h11, 5'd4, 1'b1));
        plain(0, mk(OPC_SUB, 1'b1, 32'hFFFF_0001, 32'h0, 5'd17, 1'b0, 32'hA5A5_A5A5, 5'd31, 1'b0));
        plain(0, mk(OP_LOAD, 1'b0, 32'h44, 32'h0, 5'd6, 1'b1, 32'h3, 5'd1, 1'b1));
        load(0, 1, 32'hABCC_0043, 5'd7, 1'b1, 32'd9, 5'd2, 1'b1, 32'h1234_5678);
        plain(0, mk(OP_STORE, 1'b0, 32'h40, 32'hDEAD_BEEF, 5'd9, 1'b1, 32'h21, 5'd3, 1'b1));
        load(0, 1, 32'h40, 5'd8, 1'b1, 32'h0, 5'd0, 1'b0, 32'hDEAD_BEEF);
        plain(0, idle_in());
        drain(0);

        // LOAD_LAT = 3 instance.
        load(1, 3, 32'h40, 5'd7, 1'b1, 32'd9, 5'd2, 1'b1, 32'hCAFE_F00D);
        plain(1, mk(OPC_ADD, 1'b0, 32'd42, 32'h0, 5'd5, 1'b1, 32'h66, 5'd6, 1'b1));
        // Reset while waiting: the late read data must never surface.
        step(1, mk(OP_LOAD, 1'b1, 32'h40, 32'h0, 5'd11, 1'b1, 32'h99, 5'd12, 1'b1),
             1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, bub());
        step(1, mk(OPC_ADD, 1'b0, 32'h1, 32'h0, 5'd1, 1'b1, 32'h2, 5'd2, 1'b1),
             1'b0, 1'b0, 1'b0, 1'b0, 16'h0, rst_rec());
        plain(1, mk(OPC_ADD, 1'b0, 32'h0000_0123, 32'h0, 5'd13, 1'b1, 32'h456, 5'd14, 1'b1));
        plain(1, mk(OPC_SUB, 1'b0, 32'h0000_0789, 32'h0, 5'd15, 1'b1, 32'hABC, 5'd16, 1'b0));
        plain(1, mk(OPC_ADD, 1'b0, 32'h0000_0321, 32'h0, 5'd17, 1'b0, 32'hDEF, 5'd18, 1'b1));
        plain(1, idle_in());
        drain(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
